// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared types and constants for the writeback port arbiter.
//
// Contents:
//   *_DEF       default configuration shared by wb_port_arbiter
//   FU_ID_W     width of a functional-unit index
//   wb_entry_t  one held or outgoing writeback result
//
// wb_entry_t is sized by the *_DEF widths. wb_port_arbiter takes its payload
// width parameters from these defaults, and any override must keep them
// equal.
package wb_arb_pkg;

    localparam int N_FU_DEF     = 4;
    localparam int N_WB_DEF     = 2;
    localparam int DATA_W_DEF   = 32;
    localparam int PREG_W_DEF   = 6;
    localparam int TICKET_W_DEF = 3;

    localparam int FU_ID_W = $clog2(N_FU_DEF);

    typedef struct packed {
        logic                    valid_write;
        logic [PREG_W_DEF-1:0]   pdst;
        logic [TICKET_W_DEF-1:0] ticket;
        logic [DATA_W_DEF-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/rr_multi_grant.sv
// rr_multi_grant: combinational round-robin picker that grants up to K of
// N requesters per cycle.
//
// Ports:
//   req        requesters (one bit per requester)
//   ptr        index where the scan starts
//   grant      granted requesters
//   port_idx   requester index placed on each port (port 0 = first found)
//   port_valid port carries a grant
//   next_ptr   one past the last granted index (mod N), or ptr if no grant
//
// The scan visits ptr, ptr+1, ... mod N. Ports are filled in ascending order,
// and the ports left over stay invalid with index 0.
module rr_multi_grant #(
    parameter int N = 4,
    parameter int K = 2,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]         req,
    input  logic [PW-1:0]        ptr,
    output logic [N-1:0]         grant,
    output logic [K-1:0][PW-1:0] port_idx,
    output logic [K-1:0]         port_valid,
    output logic [PW-1:0]        next_ptr
);

    always_comb begin
        int   cnt;
        int   idx;
        int   last;
        logic found;

        grant      = '0;
        port_idx   = '0;
        port_valid = '0;
        next_ptr   = ptr;
        cnt        = 0;
        idx        = 0;
        last       = 0;
        found      = 1'b0;

        for (int off = 0; off < N; off++) begin
            idx = int'(ptr) + off;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (req[idx] && (cnt < K)) begin
                grant[idx]      = 1'b1;
                port_idx[cnt]   = PW'(idx);
                port_valid[cnt] = 1'b1;
                cnt             = cnt + 1;
                last            = idx;
                found           = 1'b1;
            end
        end

        if (found) begin
            next_ptr = (last + 1 >= N) ? '0 : PW'(last + 1);
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares N_WB registered writeback ports among N_FU
// functional units.
//
// Each FU owns a one-entry holding register. A round-robin multi-grant picker
// forwards up to N_WB held results per cycle onto the writeback registers. A
// flush discards every held and outgoing result.
//
// Handshake (fu_valid_i / fu_ready_o): a result transfers at a rising edge
// where both fu_valid_i[i] and fu_ready_o[i] are high. fu_ready_o depends only
// on registered state and never on fu_valid_i. During a flush the ready is
// still honoured, and the FU treats its result as consumed, but the result is
// dropped.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   flush_i             drop all held and outgoing results (rr pointer kept)
//   fu_valid_i          FU presents a result
//   fu_ready_o          FU holding register can accept
//   fu_valid_write_i    result writes a register
//   fu_pdst_i           destination physical register per FU (flattened)
//   fu_ticket_i         ROB ticket per FU (flattened)
//   fu_data_i           result data per FU (flattened)
//   wb_valid_o          writeback port valid (registered)
//   wb_valid_write_o    port writes the register file
//   wb_pdst_o           destination register per port (flattened)
//   wb_ticket_o         ROB ticket per port (flattened)
//   wb_data_o           data per port (flattened)
//   wb_fu_id_o          source FU per port (trace)
//
// Optional build macro WB_ARB_STATS_EN adds these outputs:
//   stall_cycles_o      per-FU saturating count of held-but-not-granted cycles
//   port_full_cycles_o  saturating count of cycles with every port granted
// The counters clear on rst only.
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int N_FU     = N_FU_DEF,
    parameter int N_WB     = N_WB_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int PREG_W   = PREG_W_DEF,
    parameter int TICKET_W = TICKET_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic [N_FU-1:0]            fu_valid_i,
    output logic [N_FU-1:0]            fu_ready_o,
`ifdef WB_ARB_STATS_EN
    output logic [N_FU*32-1:0]         stall_cycles_o,
    output logic [31:0]                port_full_cycles_o,
`endif
    input  logic [N_FU-1:0]            fu_valid_write_i,
    input  logic [N_FU*PREG_W-1:0]     fu_pdst_i,
    input  logic [N_FU*TICKET_W-1:0]   fu_ticket_i,
    input  logic [N_FU*DATA_W-1:0]     fu_data_i,
    output logic [N_WB-1:0]            wb_valid_o,
    output logic [N_WB-1:0]            wb_valid_write_o,
    output logic [N_WB*PREG_W-1:0]     wb_pdst_o,
    output logic [N_WB*TICKET_W-1:0]   wb_ticket_o,
    output logic [N_WB*DATA_W-1:0]     wb_data_o,
    output logic [N_WB*FU_ID_W-1:0]    wb_fu_id_o
);

    logic [N_FU-1:0]              held_valid;
    logic [N_FU-1:0]              grant;
    logic [N_FU-1:0]              accept;
    logic [FU_ID_W-1:0]           rr_ptr;
    logic [FU_ID_W-1:0]           next_ptr;
    logic [N_WB-1:0][FU_ID_W-1:0] port_idx;
    logic [N_WB-1:0]              port_valid;

    wb_entry_t                    fu_entry [N_FU];
    wb_entry_t                    hold_q   [N_FU];

    logic [N_WB-1:0]              wb_valid_q;
    wb_entry_t                    wb_ent_q [N_WB];
    logic [N_WB-1:0][FU_ID_W-1:0] wb_fu_q;

    rr_multi_grant #(
        .N (N_FU),
        .K (N_WB)
    ) u_pick (
        .req        (held_valid),
        .ptr        (rr_ptr),
        .grant      (grant),
        .port_idx   (port_idx),
        .port_valid (port_valid),
        .next_ptr   (next_ptr)
    );

    // A granted entry leaves at this edge, so its slot can refill in the
    // same cycle. This gives one result per cycle per FU when uncontended.
    assign fu_ready_o = ~held_valid | grant;
    assign accept     = fu_valid_i & fu_ready_o;

    always_comb begin
        for (int i = 0; i < N_FU; i++) begin
            fu_entry[i].valid_write = fu_valid_write_i[i];
            fu_entry[i].pdst        = fu_pdst_i[i*PREG_W +: PREG_W];
            fu_entry[i].ticket      = fu_ticket_i[i*TICKET_W +: TICKET_W];
            fu_entry[i].data        = fu_data_i[i*DATA_W +: DATA_W];
        end
    end

    // The payload needs no reset because held_valid qualifies it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_FU; i++) begin
            if (accept[i]) begin
                hold_q[i] <= fu_entry[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            held_valid <= '0;
            rr_ptr     <= '0;
            wb_valid_q <= '0;
            wb_fu_q    <= '0;
            for (int p = 0; p < N_WB; p++) begin
                wb_ent_q[p] <= '0;
            end
        end else if (flush_i) begin
            held_valid <= '0;
            wb_valid_q <= '0;
            wb_fu_q    <= '0;
            for (int p = 0; p < N_WB; p++) begin
                wb_ent_q[p] <= '0;
            end
        end else begin
            for (int i = 0; i < N_FU; i++) begin
                if (accept[i]) begin
                    held_valid[i] <= 1'b1;
                end else if (grant[i]) begin
                    held_valid[i] <= 1'b0;
                end
            end
            for (int p = 0; p < N_WB; p++) begin
                wb_valid_q[p] <= port_valid[p];
                wb_ent_q[p]   <= port_valid[p] ? hold_q[port_idx[p]] : '0;
                wb_fu_q[p]    <= port_valid[p] ? port_idx[p] : '0;
            end
            rr_ptr <= next_ptr;
        end
    end

    always_comb begin
        wb_valid_o       = wb_valid_q;
        wb_valid_write_o = '0;
        wb_pdst_o        = '0;
        wb_ticket_o      = '0;
        wb_data_o        = '0;
        wb_fu_id_o       = '0;
        for (int p = 0; p < N_WB; p++) begin
            wb_valid_write_o[p]                   = wb_ent_q[p].valid_write;
            wb_pdst_o[p*PREG_W +: PREG_W]         = wb_ent_q[p].pdst;
            wb_ticket_o[p*TICKET_W +: TICKET_W]   = wb_ent_q[p].ticket;
            wb_data_o[p*DATA_W +: DATA_W]         = wb_ent_q[p].data;
            wb_fu_id_o[p*FU_ID_W +: FU_ID_W]      = wb_fu_q[p];
        end
    end

`ifdef WB_ARB_STATS_EN
    logic [N_FU-1:0][31:0] stall_q;
    logic [31:0]           full_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            full_q  <= '0;
        end else begin
            for (int i = 0; i < N_FU; i++) begin
                if (held_valid[i] && !grant[i] && (stall_q[i] != '1)) begin
                    stall_q[i] <= stall_q[i] + 32'd1;
                end
            end
            if ((&port_valid) && (full_q != '1)) begin
                full_q <= full_q + 32'd1;
            end
        end
    end

    assign stall_cycles_o     = stall_q;
    assign port_full_cycles_o = full_q;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: self-checking bench for wb_port_arbiter.
//
// A reference model checks every port and fu_ready_o at each falling edge.
// The model holds one slot per FU and uses a grant list built by scanning
// from the round-robin pointer. Directed phases pin the model with literal
// expectations, and a random phase follows them.
module tb_wb_port_arbiter;

    localparam int N_FU     = 4;
    localparam int N_WB     = 2;
    localparam int DATA_W   = 32;
    localparam int PREG_W   = 6;
    localparam int TICKET_W = 3;
    localparam int FU_ID_W  = 2;
    localparam int ENT_W    = 1 + PREG_W + TICKET_W + DATA_W;
    localparam int REC_W    = 1 + FU_ID_W + ENT_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                     flush_i;
    logic [N_FU-1:0]          fu_valid_i;
    logic [N_FU-1:0]          fu_ready_o;
    logic [N_FU-1:0]          fu_valid_write_i;
    logic [N_FU*PREG_W-1:0]   fu_pdst_i;
    logic [N_FU*TICKET_W-1:0] fu_ticket_i;
    logic [N_FU*DATA_W-1:0]   fu_data_i;
    logic [N_WB-1:0]          wb_valid_o;
    logic [N_WB-1:0]          wb_valid_write_o;
    logic [N_WB*PREG_W-1:0]   wb_pdst_o;
    logic [N_WB*TICKET_W-1:0] wb_ticket_o;
    logic [N_WB*DATA_W-1:0]   wb_data_o;
    logic [N_WB*FU_ID_W-1:0]  wb_fu_id_o;
`ifdef WB_ARB_STATS_EN
    logic [N_FU*32-1:0]       stall_cycles_o;
    logic [31:0]              port_full_cycles_o;
`endif

    wb_port_arbiter #(
        .N_FU     (N_FU),
        .N_WB     (N_WB),
        .DATA_W   (DATA_W),
        .PREG_W   (PREG_W),
        .TICKET_W (TICKET_W)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .flush_i            (flush_i),
        .fu_valid_i         (fu_valid_i),
        .fu_ready_o         (fu_ready_o),
`ifdef WB_ARB_STATS_EN
        .stall_cycles_o     (stall_cycles_o),
        .port_full_cycles_o (port_full_cycles_o),
`endif
        .fu_valid_write_i   (fu_valid_write_i),
        .fu_pdst_i          (fu_pdst_i),
        .fu_ticket_i        (fu_ticket_i),
        .fu_data_i          (fu_data_i),
        .wb_valid_o         (wb_valid_o),
        .wb_valid_write_o   (wb_valid_write_o),
        .wb_pdst_o          (wb_pdst_o),
        .wb_ticket_o        (wb_ticket_o),
        .wb_data_o          (wb_data_o),
        .wb_fu_id_o         (wb_fu_id_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fu(input int i, input logic vw, input logic [PREG_W-1:0] pdst,
                          input logic [TICKET_W-1:0] tk, input logic [DATA_W-1:0] data);
        fu_valid_write_i[i]                 = vw;
        fu_pdst_i[i*PREG_W +: PREG_W]       = pdst;
        fu_ticket_i[i*TICKET_W +: TICKET_W] = tk;
        fu_data_i[i*DATA_W +: DATA_W]       = data;
    endtask

    task automatic idle_inputs();
        flush_i    = 1'b0;
        fu_valid_i = '0;
    endtask

    function automatic logic [FU_ID_W-1:0] port_fu(input int p);
        return wb_fu_id_o[p*FU_ID_W +: FU_ID_W];
    endfunction

    // ---------------- scoreboard / reference model ----------------
    logic [REC_W-1:0] exp_q[$];
    logic             m_init = 1'b0;
    logic [N_FU-1:0]  m_held;
    logic [ENT_W-1:0] m_ent [N_FU];
    int               m_ptr;
    int               g[$];
    logic [N_FU-1:0]  m_gnt;
    logic [N_FU-1:0]  m_ready;

    always @(negedge clk) begin
        logic [REC_W-1:0] exp_r;
        logic [REC_W-1:0] act_r;
        int idx;

        // Compare the outputs produced by the previous rising edge.
        if (m_init && exp_q.size() >= N_WB) begin
            for (int p = 0; p < N_WB; p++) begin
                exp_r = exp_q.pop_front();
                act_r = {wb_valid_o[p], wb_fu_id_o[p*FU_ID_W +: FU_ID_W], wb_valid_write_o[p],
                         wb_pdst_o[p*PREG_W +: PREG_W], wb_ticket_o[p*TICKET_W +: TICKET_W],
                         wb_data_o[p*DATA_W +: DATA_W]};
                check($sformatf("port%0d", p), 64'(act_r), 64'(exp_r));
            end
        end

        // Find the grants this cycle: held entries in scan order, limited to N_WB.
        g.delete();
        m_gnt = '0;
        if (m_init) begin
            for (int k = 0; k < N_FU; k++) begin
                idx = (m_ptr + k) % N_FU;
                if (m_held[idx] && g.size() < N_WB) begin
                    g.push_back(idx);
                    m_gnt[idx] = 1'b1;
                end
            end
            m_ready = ~m_held | m_gnt;
            check("fu_ready", 64'(fu_ready_o), 64'(m_ready));
        end

        // Work out the effect of the coming rising edge.
        if (rst) begin
            m_init = 1'b1;
            m_held = '0;
            m_ptr  = 0;
            for (int p = 0; p < N_WB; p++) exp_q.push_back('0);
        end else if (m_init) begin
            if (flush_i) begin
                m_held = '0;
                for (int p = 0; p < N_WB; p++) exp_q.push_back('0);
            end else begin
                for (int p = 0; p < N_WB; p++) begin
                    if (p < g.size()) exp_q.push_back({1'b1, FU_ID_W'(g[p]), m_ent[g[p]]});
                    else              exp_q.push_back('0);
                end
                if (g.size() > 0) m_ptr = (g[g.size()-1] + 1) % N_FU;
                for (int i = 0; i < N_FU; i++) begin
                    if (fu_valid_i[i] && m_ready[i]) begin
                        m_held[i] = 1'b1;
                        m_ent[i]  = {fu_valid_write_i[i], fu_pdst_i[i*PREG_W +: PREG_W],
                                     fu_ticket_i[i*TICKET_W +: TICKET_W], fu_data_i[i*DATA_W +: DATA_W]};
                    end else if (m_gnt[i]) begin
                        m_held[i] = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst              = 1'b1;
        flush_i          = 1'b0;
        fu_valid_i       = '0;
        fu_valid_write_i = '0;
        fu_pdst_i        = '0;
        fu_ticket_i      = '0;
        fu_data_i        = '0;

        // Reset for two cycles.
        step();
        step();
        check("reset_wb_valid", 64'(wb_valid_o), 64'h0);
        check("reset_ready", 64'(fu_ready_o), 64'hF);
        rst = 1'b0;

        // Single result from FU2.
        set_fu(2, 1'b1, 6'd5, 3'd3, 32'h0000_1234);
        fu_valid_i = 4'b0100;
        step();
        check("single_ready_held", 64'(fu_ready_o), 64'hF);
        check("single_not_yet", 64'(wb_valid_o), 64'h0);
        idle_inputs();
        step();
        check("single_valid", 64'(wb_valid_o), 64'h1);
        check("single_data", 64'(wb_data_o[31:0]), 64'h1234);
        check("single_pdst", 64'(wb_pdst_o[5:0]), 64'd5);
        check("single_ticket", 64'(wb_ticket_o[2:0]), 64'd3);
        check("single_fu_id", 64'(port_fu(0)), 64'd2);
        step();
        check("single_drained", 64'(wb_valid_o), 64'h0);

        // Contention with the pointer back at 0.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < N_FU; i++) set_fu(i, 1'b1, PREG_W'(10 + i), TICKET_W'(i), 32'hA0 + i);
        fu_valid_i = 4'b1111;
        step();
        idle_inputs();
        check("cont_ready_t", 64'(fu_ready_o), 64'h3);
        step();
        check("cont1_valid", 64'(wb_valid_o), 64'h3);
        check("cont1_fu0", 64'(port_fu(0)), 64'd0);
        check("cont1_fu1", 64'(port_fu(1)), 64'd1);
        check("cont1_data1", 64'(wb_data_o[63:32]), 64'hA1);
        step();
        check("cont2_fu0", 64'(port_fu(0)), 64'd2);
        check("cont2_fu1", 64'(port_fu(1)), 64'd3);
        check("cont2_data0", 64'(wb_data_o[31:0]), 64'hA2);

        // Wrap-around: move the pointer to 3 with a lone FU2 grant, then hold FU3 and FU0.
        fu_valid_i = 4'b0100;
        step();
        idle_inputs();
        step();
        fu_valid_i = 4'b1001;
        step();
        idle_inputs();
        step();
        check("wrap_fu0", 64'(port_fu(0)), 64'd3);
        check("wrap_fu1", 64'(port_fu(1)), 64'd0);
        fu_valid_i = 4'b0011;
        step();
        idle_inputs();
        step();
        check("wrap_ptr1_fu0", 64'(port_fu(0)), 64'd1);
        check("wrap_ptr1_fu1", 64'(port_fu(1)), 64'd0);

        // Flush: FU1 and FU3 held, plus FU0 offered during the flush cycle.
        step();
        fu_valid_i = 4'b1010;
        step();
        fu_valid_i = 4'b0001;
        flush_i    = 1'b1;
        check("flush_ready_before", 64'(fu_ready_o), 64'hF);
        step();
        idle_inputs();
        check("flush_wb_valid", 64'(wb_valid_o), 64'h0);
        check("flush_ready", 64'(fu_ready_o), 64'hF);
        for (int k = 0; k < 3; k++) begin
            step();
            check("flush_no_leak", 64'(wb_valid_o), 64'h0);
        end

        // Fairness: every FU valid for 20 cycles, pointer starts at 0.
        rst = 1'b1;
        step();
        rst = 1'b0;
        fu_valid_i = 4'b1111;
        step();
        for (int k = 1; k < 20; k++) begin
            step();
            check("fair_valid", 64'(wb_valid_o), 64'h3);
            check("fair_fu0", 64'(port_fu(0)), (k % 2 == 1) ? 64'd0 : 64'd2);
            check("fair_fu1", 64'(port_fu(1)), (k % 2 == 1) ? 64'd1 : 64'd3);
        end
        idle_inputs();
        step();
        step();

        // Random phase; the model checks every cycle.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N_FU; i++) begin
                set_fu(i, 1'($urandom_range(0, 1)), PREG_W'($urandom), TICKET_W'($urandom), $urandom);
            end
            fu_valid_i = N_FU'($urandom);
            flush_i    = ($urandom_range(0, 15) == 0);
            rst        = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0;
        idle_inputs();
        repeat (4) step();
        check("drained_end", 64'(wb_valid_o), 64'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
